// File: rtl/pipe_stage_reg.sv
// Generic pipeline-stage register with a 2-entry (main + skid) buffer,
// flush, HOLD/BUBBLE stall modes and a saturating bubble counter.
module pipe_stage_reg #(
    parameter int                DATA_W     = 144,
    parameter logic [DATA_W-1:0] NOP_VALUE  = {DATA_W{1'b0}},
    parameter int                STALL_MODE = 1,
    parameter int                CNT_W      = 16
) (
    input  logic              cpu_clk_50M,
    input  logic              cpu_rst,
    input  logic              flush,
    input  logic              stall,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam bit               HOLD_MODE = (STALL_MODE == 0);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    logic              main_valid_q, main_valid_d;
    logic [DATA_W-1:0] main_data_q,  main_data_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;
    logic [CNT_W-1:0]  bubble_q,     bubble_d;

    logic hold_stall;
    logic in_fire;
    logic out_fire;

    // Handshake: a beat transfers on a rising edge where valid && ready are both
    // high; ready never depends on valid on the same side, and a HOLD stall
    // suppresses the downstream transfer even when out_ready is high.
    always_comb begin
        hold_stall = stall && HOLD_MODE;
        in_ready   = !skid_valid_q && !stall && !flush;
        in_fire    = in_valid && in_ready;
        out_fire   = main_valid_q && out_ready && !hold_stall;

        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        bubble_d     = bubble_q;

        if (flush) begin
            main_valid_d = 1'b0;
            main_data_d  = NOP_VALUE;
            skid_valid_d = 1'b0;
            skid_data_d  = NOP_VALUE;
        end else if (!hold_stall) begin
            // BUBBLE stall reuses this path: in_ready is low, so only draining happens.
            if (!main_valid_q || out_fire) begin
                if (skid_valid_q) begin
                    main_valid_d = 1'b1;
                    main_data_d  = skid_data_q;
                    skid_valid_d = 1'b0;
                    skid_data_d  = NOP_VALUE;
                end else if (in_fire) begin
                    main_valid_d = 1'b1;
                    main_data_d  = in_data;
                end else begin
                    main_valid_d = 1'b0;
                    main_data_d  = NOP_VALUE;
                end
            end else if (in_fire) begin
                skid_valid_d = 1'b1;
                skid_data_d  = in_data;
            end
        end

        if ((flush || !hold_stall) && !main_valid_d && (bubble_q != CNT_MAX)) begin
            bubble_d = bubble_q + CNT_ONE;
        end
    end

    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            main_valid_q <= 1'b0;
            main_data_q  <= NOP_VALUE;
            skid_valid_q <= 1'b0;
            skid_data_q  <= NOP_VALUE;
            bubble_q     <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            bubble_q     <= bubble_d;
        end
    end

    assign out_valid  = main_valid_q;
    assign out_data   = main_data_q;
    assign occupancy  = {1'b0, main_valid_q} + {1'b0, skid_valid_q};
    assign bubble_cnt = bubble_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a HOLD-mode instance (CNT_W=2) and a BUBBLE-mode
// instance share stimulus and are checked against a queue-based stage model.
module tb_pipe_stage_reg;

    localparam int          DW  = 16;
    localparam logic [15:0] NOP = 16'hA5A5;

    logic          clk = 1'b0;
    logic          rst, flush, stall, in_valid, out_ready;
    logic [DW-1:0] in_data;

    logic          in_ready_w  [2];
    logic          out_valid_w [2];
    logic [DW-1:0] out_data_w  [2];
    logic [1:0]    occ_w       [2];
    logic [15:0]   bub_w       [2];
    logic [1:0]    bub0;
    logic [15:0]   bub1;

    int            n_checks = 0;
    int            n_fail   = 0;

    logic [DW-1:0] mq    [2][$];
    logic [DW-1:0] exp_q [2][$];
    int            cnt   [2];
    int            cmax  [2];

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(DW), .NOP_VALUE(NOP), .STALL_MODE(0), .CNT_W(2)) u_hold (
        .cpu_clk_50M(clk), .cpu_rst(rst), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_ready(in_ready_w[0]), .in_data(in_data),
        .out_valid(out_valid_w[0]), .out_ready(out_ready), .out_data(out_data_w[0]),
        .occupancy(occ_w[0]), .bubble_cnt(bub0)
    );

    pipe_stage_reg #(.DATA_W(DW), .NOP_VALUE(NOP), .STALL_MODE(1), .CNT_W(16)) u_bub (
        .cpu_clk_50M(clk), .cpu_rst(rst), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_ready(in_ready_w[1]), .in_data(in_data),
        .out_valid(out_valid_w[1]), .out_ready(out_ready), .out_data(out_data_w[1]),
        .occupancy(occ_w[1]), .bubble_cnt(bub1)
    );

    assign bub_w[0] = {14'd0, bub0};
    assign bub_w[1] = bub1;

    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d @%0t: got %0h expected %0h", name, i, $time, act, exp);
        end
    endtask

    // Registered outputs against the model state left by the previous edge.
    task automatic check_state();
        for (int i = 0; i < 2; i++) begin
            chk("out_valid", i, {31'd0, out_valid_w[i]}, {31'd0, mq[i].size() > 0});
            chk("occupancy", i, {30'd0, occ_w[i]}, mq[i].size());
            chk("bubble_cnt", i, {16'd0, bub_w[i]}, cnt[i]);
            if (mq[i].size() > 0) chk("out_data", i, {16'd0, out_data_w[i]}, {16'd0, mq[i][0]});
            else                  chk("nop_data", i, {16'd0, out_data_w[i]}, {16'd0, NOP});
        end
    endtask

    task automatic bump(input int i);
        if (cnt[i] < cmax[i]) cnt[i]++;
    endtask

    // One clock: check state, drive inputs, check in_ready, advance the model.
    task automatic cycle(input logic r, input logic f, input logic s, input logic iv,
                         input logic [DW-1:0] d, input logic ordy);
        logic rdy;
        check_state();
        rst = r; flush = f; stall = s; in_valid = iv; in_data = d; out_ready = ordy;
        #1;
        for (int i = 0; i < 2; i++) begin
            rdy = (mq[i].size() < 2) && !s && !f;
            chk("in_ready", i, {31'd0, in_ready_w[i]}, {31'd0, rdy});
            if (r) begin
                mq[i].delete();
                cnt[i] = 0;
            end else if (f) begin
                mq[i].delete();
                bump(i);
            end else if (!(s && i == 0)) begin
                if (mq[i].size() > 0 && ordy) void'(mq[i].pop_front());
                if (iv && rdy) begin
                    mq[i].push_back(d);
                    exp_q[i].push_back(d);
                end
                if (mq[i].size() == 0) bump(i);
            end
        end
        @(posedge clk);
        #2;
    endtask

    // Monitor: whenever a DUT hands a beat downstream, it must be the oldest
    // accepted, not-yet-delivered, not-flushed beat.
    initial begin
        logic [DW-1:0] e;
        forever begin
            @(posedge clk);
            #8;
            for (int i = 0; i < 2; i++) begin
                if (in_valid && in_ready_w[i] && occ_w[i] == 2'd2) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL skid_overrun dut%0d @%0t: accept with occupancy %0d required <2", i, $time, occ_w[i]);
                end
                if (!rst && out_valid_w[i] && out_ready && !(stall && i == 0)) begin
                    if (exp_q[i].size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL sb_empty dut%0d @%0t: got %0h expected no beat", i, $time, out_data_w[i]);
                    end else begin
                        e = exp_q[i].pop_front();
                        chk("sb_data", i, {16'd0, out_data_w[i]}, {16'd0, e});
                    end
                end
                if (rst || flush) exp_q[i].delete();
            end
        end
    end

    initial begin
        cmax[0] = 3;
        cmax[1] = 65535;
        cnt[0]  = 0;
        cnt[1]  = 0;
        rst = 1'b1; flush = 1'b0; stall = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        @(posedge clk);
        #2;

        // Reset, then a back-to-back stream of 1,2,3.
        cycle(1, 0, 0, 0, 16'h0, 1);
        cycle(1, 0, 0, 0, 16'h0, 1);
        cycle(0, 0, 0, 0, 16'h0, 1);
        for (int k = 1; k <= 3; k++) cycle(0, 0, 0, 1, k[15:0], 1);
        // Idle long enough to saturate the 2-bit counter.
        for (int k = 0; k < 5; k++) cycle(0, 0, 0, 0, 16'h0, 1);

        // Backpressure into the skid slot.
        cycle(0, 0, 0, 1, 16'hA, 0);
        cycle(0, 0, 0, 1, 16'hB, 0);
        cycle(0, 0, 0, 1, 16'hC, 0);
        cycle(0, 0, 0, 1, 16'hC, 1);
        cycle(0, 0, 0, 1, 16'hC, 1);
        for (int k = 0; k < 3; k++) cycle(0, 0, 0, 0, 16'h0, 1);

        // Full stage under a 3-cycle stall, then release.
        cycle(0, 0, 0, 1, 16'h5, 0);
        cycle(0, 0, 0, 1, 16'h6, 0);
        for (int k = 0; k < 3; k++) cycle(0, 0, 1, 1, 16'h7, 1);
        for (int k = 0; k < 3; k++) cycle(0, 0, 0, 0, 16'h0, 1);

        // Single beat then a 2-cycle stall.
        cycle(0, 0, 0, 1, 16'h7, 0);
        cycle(0, 0, 1, 1, 16'h70, 1);
        cycle(0, 0, 1, 1, 16'h71, 1);
        cycle(0, 0, 0, 0, 16'h0, 1);

        // Flush together with stall and an offered beat.
        cycle(0, 0, 0, 1, 16'h8, 0);
        cycle(0, 0, 0, 1, 16'h18, 0);
        cycle(0, 1, 1, 1, 16'h9, 1);
        cycle(0, 0, 0, 0, 16'h0, 1);
        cycle(0, 0, 0, 1, 16'h1A, 1);
        cycle(0, 0, 0, 0, 16'h0, 1);

        // Reset while full.
        cycle(0, 0, 0, 1, 16'h33, 0);
        cycle(0, 0, 0, 1, 16'h44, 0);
        cycle(1, 0, 0, 1, 16'h77, 1);
        cycle(0, 0, 0, 0, 16'h0, 1);

        // Random traffic.
        for (int k = 0; k < 3000; k++) begin
            cycle($urandom_range(199, 0) == 0, $urandom_range(19, 0) == 0,
                  $urandom_range(5, 0) == 0, $urandom_range(3, 0) != 0,
                  16'($urandom), $urandom_range(2, 0) != 0);
        end
        check_state();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised, generic pipeline-stage register for the MiniMIPS32 datapath: one instance per stage boundary (IF/ID, ID/EXE, EXE/MEM, MEM/WB).
- Carries an opaque payload bus with a valid/ready handshake.
- A 2-entry skid slot lets upstream keep issuing for one cycle after downstream deasserts ready.
- Supports flush, hazard-unit stall in HOLD or BUBBLE mode, and a saturating bubble counter for performance debug.

Parameters:
- DATA_W, 144, payload width in bits (aluop 8 + wa 5 + wreg/whilo/mreg 3 + wd 32 + din 32 + hilo 64).
- NOP_VALUE, {DATA_W{1'b0}}, payload driven when the output slot is empty (decodes as SLL $0 with all write-enables off).
- STALL_MODE, 1, 0 = HOLD: freeze the stage. 1 = BUBBLE: drain, then insert NOPs.
- CNT_W, 16, width of the bubble counter.

Ports:
- cpu_clk_50M  in  1  clock, all state on the rising edge.
- cpu_rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all stage contents (exception/branch redirect).
- stall  in  1  hazard-unit stop request for this stage.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  stage can accept; combinational = !skid_valid && !stall && !flush.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  output slot holds a real instruction (registered).
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  output payload (registered); equals NOP_VALUE whenever out_valid=0.
- occupancy  out  2  entries held: 0, 1 or 2.
- bubble_cnt  out  CNT_W  count of cycles in which out_valid=0 after the edge.

Behaviour:
- State:
  - main slot (out_valid, out_data).
  - skid slot (skid_valid, skid_data).
  - bubble_cnt.
- Reset (cpu_rst=1 at the edge):
  - out_valid=0, out_data=NOP_VALUE.
  - skid_valid=0, skid_data=NOP_VALUE.
  - bubble_cnt=0, occupancy=0.
  - Reset overrides flush, stall and all handshake inputs, including mid-transfer.
- Priority at each edge: cpu_rst > flush > stall > normal.
- Fire definitions:
  - in_fire = in_valid && in_ready.
  - out_fire = out_valid && out_ready && !(stall && STALL_MODE==0).
- Normal operation (no stall, no flush), resolved in this order:
  - Main slot empty or out_fire:
    - If skid_valid: main <= skid, skid_valid <= 0.
    - Else if in_fire: main <= in_data.
    - Else: main <= NOP_VALUE, out_valid <= 0.
  - Main slot held (valid, not consumed):
    - If in_fire: skid <= in_data, skid_valid <= 1.
  - If skid moves to main and in_fire happens in the same cycle, in_data goes to skid. This cannot occur because in_ready=0 while skid_valid=1; any attempt is an assertion error in the bench.
- Latency and throughput:
  - One cycle in_data -> out_data when empty.
  - Full throughput: one beat per cycle while out_ready=1.
- Full: occupancy=2 forces in_ready=0.
- Empty: occupancy=0 with out_data=NOP_VALUE.
- Stall, HOLD (STALL_MODE=0):
  - No accept, no consume.
  - Both slots and out_data unchanged.
  - bubble_cnt unchanged.
- Stall, BUBBLE (STALL_MODE=1):
  - No accept; downstream may still consume.
  - On out_fire: skid advances if valid, otherwise main becomes NOP with out_valid=0.
  - A held main slot stays held.
- Flush:
  - Both slots are invalidated: out_valid=0, out_data=NOP_VALUE, skid_valid=0.
  - The beat offered in the flush cycle is dropped (in_ready=0).
  - in_ready returns to 1 on the next cycle if stall=0.
- Flush with stall simultaneously: flush wins.
- bubble_cnt:
  - Increments when the next out_valid is 0, excluding reset and HOLD-stall cycles.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - Cleared only by reset.
- occupancy = out_valid + skid_valid (registered state).

Test Plan:
- Reset then stream: hold cpu_rst=1 for 2 cycles, then in_data=1,2,3 on consecutive cycles with out_ready=1 -> out_data=1,2,3 one cycle later each. out_valid=1 for 3 cycles; occupancy stays 1; bubble_cnt=1 (the cycle before the first beat).
- Backpressure/skid: stream 0xA,0xB,0xC while out_ready drops at 0xA -> in_ready=0 after 0xB, occupancy=2, out_data holds 0xA. On out_ready=1, output shows 0xA, then 0xB, then 0xC, with no loss or duplication.
- HOLD stall (STALL_MODE=0): occupancy=2 with 0x5,0x6, stall=1 for 3 cycles with out_ready=1 -> out_data=0x5 stable, in_ready=0, bubble_cnt unchanged. Release -> 0x5, then 0x6.
- BUBBLE stall (STALL_MODE=1): main=0x7, stall=1 for 2 cycles with out_ready=1 -> next out_data=NOP_VALUE, out_valid=0. bubble_cnt +2; in_valid beats are not accepted.
- Flush mid-stream: occupancy=2, assert flush together with stall=1 and in_valid=1, in_data=0x9 -> next cycle out_valid=0, out_data=NOP_VALUE, occupancy=0; 0x9 never appears at the output.
- Saturation and reset mid-op: CNT_W=2, 5 idle cycles -> bubble_cnt=3 (held). Assert cpu_rst while occupancy=2 -> all outputs return to reset values on the next edge.
